// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - serial transmit controller sequencing a PISO shift register
module piso_tx_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             sout,
    output logic             sout_valid,
    output logic             sl,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    // Bit counter spans 0..WIDTH-1; gap counter spans 0..GAP_CYCLES-1 and
    // keeps one bit even when the gap is disabled so the vector stays legal.
    localparam int BW      = $clog2(WIDTH);
    localparam int GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [CNT_W-1:0] r_frames;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_sl;
    logic             r_done;

    logic w_last_bit;
    logic w_gap_last;

    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_gap_last = (r_gap_cnt == GAP_LAST);

    // Ready is combinational so the source sees it in the same cycle the
    // controller returns to IDLE; it is forced low while reset is held.
    assign din_ready   = (r_state == S_IDLE) & ~rst;

    assign sout        = r_sout;
    assign sout_valid  = r_sout_valid;
    assign sl          = r_sl;
    assign done        = r_done;
    assign frames_sent = r_frames;

    // Frame sequencer: load, shift MSB first, optional idle gap; the serial
    // outputs are registered alongside the state so they always track shreg.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_frames     <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sl         <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // flush outranks an offered word: nothing is taken
                    if (!flush && din_valid) begin
                        r_shreg      <= din;
                        r_bit_cnt    <= '0;
                        r_sout       <= din[WIDTH-1];
                        r_sout_valid <= 1'b1;
                        r_sl         <= 1'b1;
                        r_state      <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (flush) begin
                        // abort: no done pulse, counter untouched
                        r_shreg      <= '0;
                        r_bit_cnt    <= '0;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_sl         <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_last_bit) begin
                        r_done       <= 1'b1;
                        r_frames     <= r_frames + 1'b1;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_sl         <= 1'b0;
                        r_gap_cnt    <= '0;
                        if (HAS_GAP) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_sout    <= r_shreg[WIDTH-2];
                    end
                end

                S_GAP: begin
                    if (flush) begin
                        r_shreg   <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else if (w_gap_last) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_sl         <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb/tb_piso_tx_ctrl.sv - self-checking bench for piso_tx_ctrl
module tb_piso_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a_din = 4'd0;
    logic       a_din_valid = 1'b0;
    logic       a_flush = 1'b0;
    logic       a_din_ready, a_sout, a_sout_valid, a_sl, a_done;
    logic [7:0] a_frames;

    logic [3:0] b_din = 4'd0;
    logic       b_din_valid = 1'b0;
    logic       b_flush = 1'b0;
    logic       b_din_ready, b_sout, b_sout_valid, b_sl, b_done;
    logic [7:0] b_frames;

    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid),
        .din_ready(a_din_ready), .flush(a_flush), .sout(a_sout),
        .sout_valid(a_sout_valid), .sl(a_sl), .done(a_done),
        .frames_sent(a_frames)
    );

    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid),
        .din_ready(b_din_ready), .flush(b_flush), .sout(b_sout),
        .sout_valid(b_sout_valid), .sl(b_sl), .done(b_done),
        .frames_sent(b_frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int a_done_cnt = 0;
    bit exp_q[$];

    // flush_at: -1 none, -2 flush together with an offer in IDLE, k>=0 flush during bit k
    typedef struct {
        logic [3:0] din;
        int         flush_at;
        logic [7:0] exp_frames;
        int         exp_done;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // serial monitor for dut_a: every valid bit is popped from the scoreboard
    task automatic mon_a();
        bit e;
        forever begin
            @(posedge clk);
            if (a_done === 1'b1) a_done_cnt++;
            if (a_sout_valid === 1'b1) begin
                chk("bit_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("serial_bit_sl", 32'({a_sl, a_sout}), 32'({1'b1, e}));
                end
            end
        end
    endtask

    task automatic wait_idle_a(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (a_din_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int nb;
        a_din       = v.din;
        a_din_valid = 1'b1;
        a_flush     = (v.flush_at == -2);
        if (v.flush_at != -2) begin
            nb = (v.flush_at < 0) ? 4 : v.flush_at + 1;
            for (int k = 0; k < nb; k++) exp_q.push_back(v.din[3-k]);
        end
        sync();
        a_din_valid = 1'b0;
        a_flush     = 1'b0;
        a_din       = 4'($urandom);
        if (v.flush_at == -2) begin
            @(posedge clk);
            chk("idle_flush_no_accept", 32'({a_sout_valid, a_din_ready}), 32'b01);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k == v.flush_at) a_flush = 1'b1;
                sync();
                a_flush = 1'b0;
                if (k == v.flush_at) break;
            end
            if (v.flush_at >= 0) begin
                @(posedge clk);
                chk("flush_next_cycle", 32'({a_sout_valid, a_sl, a_done, a_din_ready}), 32'b0001);
            end
        end
        wait_idle_a("vec_idle");
        chk("vec_frames", 32'(a_frames), 32'(v.exp_frames));
        chk("vec_done_cnt", 32'(a_done_cnt), 32'(v.exp_done));
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [23:0] smp_v, smp_d, exp_v, exp_d;
        logic [3:0]  w1, w2;
        logic        rdy;
        int          nacc, bdn, acc, dn;

        vt[0] = '{din: 4'b1011, flush_at: -1, exp_frames: 8'd2, exp_done: 2};
        vt[1] = '{din: 4'b0110, flush_at: -1, exp_frames: 8'd3, exp_done: 3};
        vt[2] = '{din: 4'b1111, flush_at:  2, exp_frames: 8'd3, exp_done: 3};
        vt[3] = '{din: 4'b0001, flush_at: -2, exp_frames: 8'd3, exp_done: 3};
        vt[4] = '{din: 4'b1000, flush_at:  0, exp_frames: 8'd3, exp_done: 3};
        vt[5] = '{din: 4'b0101, flush_at:  3, exp_frames: 8'd3, exp_done: 3};
        vt[6] = '{din: 4'b1110, flush_at: -1, exp_frames: 8'd4, exp_done: 4};

        fork
            mon_a();
        join_none

        // reset: everything low, offered word must not be seen as ready
        a_din = 4'b1010;
        a_din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            chk("rst_outputs_a", 32'({a_sout, a_sout_valid, a_sl, a_done, a_din_ready}), 32'd0);
            chk("rst_frames_a", 32'(a_frames), 32'd0);
            chk("rst_outputs_b", 32'({b_sout, b_sout_valid, b_sl, b_done, b_din_ready, b_frames}), 32'd0);
        end
        sync();
        rst = 1'b0;
        a_din_valid = 1'b0;
        @(posedge clk);
        chk("post_rst_ready", 32'({a_din_ready, b_din_ready}), 32'b11);
        chk("post_rst_frames", 32'(a_frames), 32'd0);
        sync();

        // single frame 1011 with exact per-cycle timing
        a_din = 4'b1011;
        a_din_valid = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(a_din[3-k]);
        sync();
        a_din_valid = 1'b0;
        a_din = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            chk("t2_bit_cycle", 32'({a_sout_valid, a_sl, a_done, a_din_ready}), 32'b1100);
        end
        @(posedge clk);
        chk("t2_done_cycle", 32'({a_done, a_sout_valid, a_sl, a_din_ready}), 32'b1000);
        chk("t2_frames", 32'(a_frames), 32'd1);
        @(posedge clk);
        chk("t2_ready_back", 32'({a_din_ready, a_done}), 32'b10);
        sync();

        // back-to-back frames on the GAP_CYCLES=2 instance with valid held high
        w1 = 4'b1011;
        w2 = 4'b0110;
        b_din = w1;
        b_din_valid = 1'b1;
        nacc = 0;
        bdn = 0;
        smp_v = '0;
        smp_d = '0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            smp_v[c] = b_sout_valid;
            smp_d[c] = b_sout;
            rdy = b_din_ready;
            if (b_done === 1'b1) bdn++;
            sync();
            if (rdy && b_din_valid) begin
                nacc++;
                if (nacc == 1) b_din = w2;
                else b_din_valid = 1'b0;
            end
        end
        exp_v = '0;
        exp_d = '0;
        for (int k = 0; k < 4; k++) begin
            exp_v[1+k] = 1'b1;
            exp_v[8+k] = 1'b1;
            exp_d[1+k] = w1[3-k];
            exp_d[8+k] = w2[3-k];
        end
        chk("t3_valid_pattern", 32'(smp_v), 32'(exp_v));
        chk("t3_data_pattern", 32'(smp_d), 32'(exp_d));
        chk("t3_frames", 32'(b_frames), 32'd2);
        chk("t3_done_pulses", 32'(bdn), 32'd2);

        // table of frames, flushes and idle-flush cases
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // asynchronous reset in the middle of bit 1
        a_din = 4'b1011;
        a_din_valid = 1'b1;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        sync();
        a_din_valid = 1'b0;
        sync();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_async_outputs", 32'({a_sout, a_sout_valid, a_sl, a_done, a_din_ready}), 32'd0);
        chk("t5_async_frames", 32'(a_frames), 32'd0);
        sync();
        rst = 1'b0;
        @(posedge clk);
        chk("t5_ready_after", 32'({a_din_ready, a_sout_valid}), 32'b10);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        sync();

        // 256 back-to-back random frames: counter wraps to 0
        a_din = 4'($urandom);
        a_din_valid = 1'b1;
        acc = 0;
        dn = 0;
        for (int c = 0; c < 2000 && dn < 256; c++) begin
            @(posedge clk);
            rdy = a_din_ready;
            if (a_done === 1'b1) begin
                dn++;
                if (dn == 255) chk("t6_frames_255", 32'(a_frames), 32'd255);
                if (dn == 256) chk("t6_frames_wrap", 32'(a_frames), 32'd0);
            end
            sync();
            if (rdy && a_din_valid) begin
                for (int k = 0; k < 4; k++) exp_q.push_back(a_din[3-k]);
                acc++;
                a_din = 4'($urandom);
                if (acc == 256) a_din_valid = 1'b0;
            end
        end
        chk("t6_done_pulses", 32'(dn), 32'd256);
        for (int i = 0; i < 4; i++) sync();
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_idle", 32'({a_din_ready, a_sout_valid}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
